// File: rtl/reg_skid_stage.sv
// Registered valid/ready skid buffer (main + skid word) with flop-driven s_ready/m_valid.
// Optional transfer counter enabled by defining SKID_XFER_COUNT_EN.
module reg_skid_stage #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data
`ifdef SKID_XFER_COUNT_EN
    ,
    output logic [COUNT_W-1:0] xfer_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_p0, main_d;
    logic [WIDTH-1:0] skid_p0, skid_d;
    logic             m_valid_p0, s_ready_p0;
    logic             s_fire, m_fire;

    assign s_fire  = s_valid & s_ready_p0;
    assign m_fire  = m_valid_p0 & m_ready;
    assign s_ready = s_ready_p0;
    assign m_valid = m_valid_p0;
    assign m_data  = main_p0;

    always_comb begin
        state_d = state_q;
        main_d  = main_p0;
        skid_d  = skid_p0;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (s_fire) begin
                        state_d = BUSY;
                        main_d  = s_data;
                    end
                end
                BUSY: begin
                    if (s_fire && !m_fire) begin
                        state_d = FULL;
                        skid_d  = s_data;
                    end else if (!s_fire && m_fire) begin
                        state_d = EMPTY;
                    end else if (s_fire && m_fire) begin
                        main_d  = s_data;
                    end
                end
                FULL: begin
                    // s_ready is low here, so only the consumer side can move
                    if (m_fire) begin
                        state_d = BUSY;
                        main_d  = skid_p0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so neither has a comb path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            m_valid_p0 <= 1'b0;
            s_ready_p0 <= 1'b1;
            main_p0    <= '0;
            skid_p0    <= '0;
        end else begin
            state_q    <= state_d;
            m_valid_p0 <= (state_d != EMPTY);
            s_ready_p0 <= (state_d != FULL);
            main_p0    <= main_d;
            skid_p0    <= skid_d;
        end
    end

`ifdef SKID_XFER_COUNT_EN
    // Counts completed output transfers; flush does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (m_fire) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_skid_stage.sv
// Directed self-checking bench for reg_skid_stage; counter checks run when
// SKID_XFER_COUNT_EN is defined (instantiated with COUNT_W=4).
module tb_reg_skid_stage;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
`ifdef SKID_XFER_COUNT_EN
    logic [COUNT_W-1:0] xfer_count;
`endif

    int checks = 0;
    int fails  = 0;

    reg_skid_stage #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef SKID_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream [4];

    initial begin
        stream[0] = 32'h12345678;
        stream[1] = 32'h87654321;
        stream[2] = 32'hDEADBEEF;
        stream[3] = 32'h0F0F0F0F;

        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #12;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_data",  m_data,  0);
`ifdef SKID_XFER_COUNT_EN
        chk("rst_count", xfer_count, 0);
`endif
        rst_n = 1'b1;
        #4;

        // single word, consumer ready
        s_valid = 1'b1; s_data = 32'hAAAAAAAA; m_ready = 1'b1;
        step();
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_data",  m_data,  32'hAAAAAAAA);
        chk("t1_s_ready", s_ready, 1);
        s_valid = 1'b0;
        step();
        chk("t1_drain_m_valid", m_valid, 0);

        // back-pressure fills main and skid
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h55555555;
        step();
        chk("t2_busy_s_ready", s_ready, 1);
        s_data = 32'hFFFFFFFF;
        step();
        chk("t2_full_s_ready", s_ready, 0);
        chk("t2_full_m_data",  m_data,  32'h55555555);
        s_valid = 1'b0; s_data = 32'h00000000;
        step();
        chk("t2_hold_m_valid", m_valid, 1);
        chk("t2_hold_m_data",  m_data,  32'h55555555);
        m_ready = 1'b1;
        step();
        chk("t2_second_m_data",  m_data,  32'hFFFFFFFF);
        chk("t2_second_m_valid", m_valid, 1);
        chk("t2_second_s_ready", s_ready, 1);
        step();
        chk("t2_drain_m_valid", m_valid, 0);

        // streaming: one word per cycle
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = stream[i];
            step();
            chk("t3_m_data",  m_data,  stream[i]);
            chk("t3_m_valid", m_valid, 1);
            chk("t3_s_ready", s_ready, 1);
        end
        s_valid = 1'b0;
        step();
        chk("t3_drain_m_valid", m_valid, 0);
`ifdef SKID_XFER_COUNT_EN
        chk("t3_count", xfer_count, 7);
`endif

        // flush from FULL
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h11111111;
        step();
        s_data = 32'h22222222;
        step();
        chk("t4_full_s_ready", s_ready, 0);
        s_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_m_valid", m_valid, 0);
        chk("t4_flush_s_ready", s_ready, 1);
        chk("t4_flush_m_data",  m_data,  0);
`ifdef SKID_XFER_COUNT_EN
        chk("t4_flush_count", xfer_count, 7);
`endif
        s_valid = 1'b1; s_data = 32'h00000000;
        step();
        chk("t4_push_m_valid", m_valid, 1);
        chk("t4_push_m_data",  m_data,  0);
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        chk("t4_drain_m_valid", m_valid, 0);

`ifdef SKID_XFER_COUNT_EN
        // nine more transfers bring the total to 17, wrapping a 4-bit counter to 1
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_data = 32'hC0DE0000 + i;
            step();
        end
        s_valid = 1'b0;
        step();
        chk("t6_wrap_count", xfer_count, 1);
`endif

        // async reset while FULL
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h33333333;
        step();
        s_data = 32'h44444444;
        step();
        chk("t5_full_s_ready", s_ready, 0);
        chk("t5_full_m_valid", m_valid, 1);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_arst_m_valid", m_valid, 0);
        chk("t5_arst_s_ready", s_ready, 1);
        chk("t5_arst_m_data",  m_data,  0);
`ifdef SKID_XFER_COUNT_EN
        chk("t5_arst_count", xfer_count, 0);
`endif
        #2;
        rst_n = 1'b1;
        step();
        chk("t5_post_m_valid", m_valid, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
